// File: rtl/mux157_arbiter.sv
// ============================================================================
// mux157_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Two-requester arbiter for one 74LS157 quad 2:1 mux that is shared by
//   sources A and B on a 4-bit bus segment. The arbiter drives the mux select
//   (pin 1) and the active-low strobe (pin 15).
//
//   Break-before-make: the strobe is high while the select moves, and it stays
//   high for SETTLE_CYCLES more cycles before the new owner is granted. When
//   both sources request at the same time, the arbiter alternates between them
//   (round robin).
//
// Parameters:
//   SETTLE_CYCLES  strobe-high cycles after the select moves, before the
//                  grant (0..15)
//   MAX_HOLD       grant length in cycles that forces a release (1..255).
//                  Used only in the timeout build.
//   PRIORITY_B     value of last_owner at reset. 0 means B wins the first tie.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   req_a, req_b   in   level requests, held until the transfer is done
//   gnt_a, gnt_b   out  current owner of the mux
//   mux_sel        out  74LS157 pin 1 (0 = A inputs, 1 = B inputs)
//   mux_strobe_n   out  74LS157 pin 15 (1 = all mux outputs forced 0)
//   busy           out  arbiter is not idle
//   last_owner     out  owner of the most recently ended grant (0 = A, 1 = B)
//   timeout_pulse  out  one-cycle pulse on a forced release
//
// Configuration:
//   MUX157_ARB_TIMEOUT_EN  When defined, a grant is forced to end after
//                          MAX_HOLD cycles. The source that was forced out is
//                          then locked out until its request is seen low once.
//                          When undefined, grants have no length limit and
//                          timeout_pulse is tied low.
// ============================================================================
module mux157_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned MAX_HOLD      = 16,
    parameter bit          PRIORITY_B    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic mux_sel,
    output logic mux_strobe_n,
    output logic busy,
    output logic last_owner,
    output logic timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        GRANT_A = 2'd2,
        GRANT_B = 2'd3
    } state_t;

    // The settle counter counts down to zero, so it is loaded with one less
    // than the number of settle cycles.
    localparam logic [3:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    // Parameter ranges are checked at elaboration time.
    if (SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("mux157_arbiter: SETTLE_CYCLES must be 0..15");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux157_arbiter: MAX_HOLD must be 1..255");
    end

    state_t     state;
    state_t     state_next;
    logic       sel_q;
    logic       sel_next;
    logic [3:0] cnt_q;
    logic [3:0] cnt_next;
    logic       last_q;
    logic       last_next;
    logic       gnt_a_q;
    logic       gnt_b_q;
    logic       strobe_n_q;
    logic       busy_q;
    logic       elig_a;
    logic       elig_b;
    logic       win_b;

`ifdef MUX157_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q;
    logic       lock_a_q;
    logic       lock_b_q;
    logic       pulse_q;
    logic       forced;

    // A source that was forced out of its grant cannot take part in
    // arbitration until it drops its request.
    assign elig_a        = req_a & ~lock_a_q;
    assign elig_b        = req_b & ~lock_b_q;
    assign timeout_pulse = pulse_q;

    // Timeout bookkeeping.
    // The hold counter is zero outside the grant states, so it starts from
    // zero on every grant entry. Its value at an edge is the number of grant
    // cycles already spent minus one. A lockout flag clears as soon as its
    // request is sampled low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= 8'd0;
            lock_a_q <= 1'b0;
            lock_b_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            hold_q  <= (state == GRANT_A || state == GRANT_B) ? hold_q + 8'd1 : 8'd0;
            pulse_q <= forced;
            if (!req_a) begin
                lock_a_q <= 1'b0;
            end else if (forced && state == GRANT_A) begin
                lock_a_q <= 1'b1;
            end
            if (!req_b) begin
                lock_b_q <= 1'b0;
            end else if (forced && state == GRANT_B) begin
                lock_b_q <= 1'b1;
            end
        end
    end
`else
    assign elig_a        = req_a;
    assign elig_b        = req_b;
    assign timeout_pulse = 1'b0;
`endif

    // Next-state and next-output logic.
    //
    // Winner selection in IDLE: the only eligible requester wins. On a tie,
    // the source that did not own the last grant wins.
    //
    // During SETTLE the select stays frozen. The only way out before the
    // grant is an abort, which happens when the chosen source drops its
    // request. A request from the other source never preempts.
    always_comb begin
        state_next = state;
        sel_next   = sel_q;
        cnt_next   = cnt_q;
        last_next  = last_q;
        win_b      = 1'b0;
`ifdef MUX157_ARB_TIMEOUT_EN
        forced     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (elig_a || elig_b) begin
                    win_b    = elig_b & (~elig_a | ~last_q);
                    sel_next = win_b;
                    if (SETTLE_CYCLES == 0) begin
                        state_next = win_b ? GRANT_B : GRANT_A;
                    end else begin
                        state_next = SETTLE;
                        cnt_next   = SETTLE_LOAD;
                    end
                end
            end
            SETTLE: begin
                if (sel_q ? !req_b : !req_a) begin
                    state_next = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_next = sel_q ? GRANT_B : GRANT_A;
                end else begin
                    cnt_next = cnt_q - 4'd1;
                end
            end
            GRANT_A: begin
                if (!req_a) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                end
`ifdef MUX157_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                    forced     = 1'b1;
                end
`endif
            end
            GRANT_B: begin
                if (!req_b) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                end
`ifdef MUX157_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                    forced     = 1'b1;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and output flops.
    // All outputs are registered from the next state, so the pins never see
    // decode glitches. The strobe is released (driven low) only in the grant
    // states, which keeps it high whenever the select can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_q      <= 1'b0;
            cnt_q      <= 4'd0;
            last_q     <= PRIORITY_B;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            strobe_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_next;
            sel_q      <= sel_next;
            cnt_q      <= cnt_next;
            last_q     <= last_next;
            gnt_a_q    <= (state_next == GRANT_A);
            gnt_b_q    <= (state_next == GRANT_B);
            strobe_n_q <= !(state_next == GRANT_A || state_next == GRANT_B);
            busy_q     <= (state_next != IDLE);
        end
    end

    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign mux_sel      = sel_q;
    assign mux_strobe_n = strobe_n_q;
    assign busy         = busy_q;
    assign last_owner   = last_q;

endmodule

// File: tb/tb_mux157_arbiter.sv
// ============================================================================
// tb_mux157_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Scoreboard testbench for mux157_arbiter. It uses two instances:
//     dut1  SETTLE_CYCLES=1, MAX_HOLD=4
//     dut3  SETTLE_CYCLES=3
//
//   The stimulus pushes the hand-derived output vector, together with the
//   cycle it should appear in, into a queue for each instance. A monitor that
//   samples on the falling edge pops and compares an entry whenever that
//   instance's outputs change.
//
//   Output vector bit order:
//     {gnt_a, gnt_b, mux_sel, mux_strobe_n, busy, last_owner, timeout_pulse}
//
//   Timeout section: MUX157_ARB_TIMEOUT_EN selects the timeout scenario
//   instead of the long-hold scenario.
// ============================================================================
module tb_mux157_arbiter;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    logic clk;
    logic rst_n;
    logic req_a, req_b, req3_a, req3_b;
    logic gnt_a, gnt_b, mux_sel, mux_strobe_n, busy, last_owner, timeout_pulse;
    logic gnt3_a, gnt3_b, sel3, strobe3_n, busy3, last3, tp3;

    int   cyc;
    int   num_checks;
    int   num_fails;
    bit   mon_en;
    exp_t q1[$];
    exp_t q3[$];
    logic [6:0] prev1;
    logic [6:0] prev3;

    mux157_arbiter #(.SETTLE_CYCLES(1), .MAX_HOLD(4), .PRIORITY_B(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .mux_sel(mux_sel), .mux_strobe_n(mux_strobe_n),
        .busy(busy), .last_owner(last_owner), .timeout_pulse(timeout_pulse)
    );

    mux157_arbiter #(.SETTLE_CYCLES(3), .MAX_HOLD(16), .PRIORITY_B(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_a(req3_a), .req_b(req3_b),
        .gnt_a(gnt3_a), .gnt_b(gnt3_b), .mux_sel(sel3), .mux_strobe_n(strobe3_n),
        .busy(busy3), .last_owner(last3), .timeout_pulse(tp3)
    );

    wire [6:0] vec1 = {gnt_a, gnt_b, mux_sel, mux_strobe_n, busy, last_owner, timeout_pulse};
    wire [6:0] vec3 = {gnt3_a, gnt3_b, sel3, strobe3_n, busy3, last3, tp3};

    // 10-unit clock and an edge counter. Falling-edge code sees a stable count.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports each failure.
    task automatic checkOutput(input string name, input int act, input int exp);
        num_checks++;
        if (act != exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives all four requests, then waits n falling edges.
    task automatic applyStimulus(input logic a, input logic b, input logic a3,
                                 input logic b3, input int n);
        req_a  = a;
        req_b  = b;
        req3_a = a3;
        req3_b = b3;
        repeat (n) @(negedge clk);
    endtask

    // Queues an expected output vector, dt edges from now.
    task automatic expect1(input int dt, input logic [6:0] v);
        q1.push_back('{cyc: cyc + dt, vec: v});
    endtask

    task automatic expect3(input int dt, input logic [6:0] v);
        q3.push_back('{cyc: cyc + dt, vec: v});
    endtask

    // Structural invariants for one instance. The select may only move while
    // the strobe is high, both before and after the move.
    task automatic checkInvariants(input string who, input logic [6:0] cur,
                                   input logic [6:0] prev);
        checkOutput({who, "_inv_overlap"}, int'(cur[6] & cur[5]), 0);
        checkOutput({who, "_inv_gnt_pins"},
                    int'((cur[6] | cur[5]) & (cur[3] | (cur[4] != cur[5]))), 0);
        checkOutput({who, "_inv_sel_move"},
                    int'((cur[4] != prev[4]) & ~(cur[3] & prev[3])), 0);
    endtask

    // Monitor: compares each output change against the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            checkInvariants("dut1", vec1, prev1);
            checkInvariants("dut3", vec3, prev3);
            if (vec1 !== prev1) begin
                if (q1.size() == 0) begin
                    checkOutput("dut1_unexpected_change", int'(vec1), int'(prev1));
                end else begin
                    e = q1.pop_front();
                    checkOutput("dut1_event_vec", int'(vec1), int'(e.vec));
                    checkOutput("dut1_event_cycle", cyc, e.cyc);
                end
                prev1 = vec1;
            end
            if (vec3 !== prev3) begin
                if (q3.size() == 0) begin
                    checkOutput("dut3_unexpected_change", int'(vec3), int'(prev3));
                end else begin
                    e = q3.pop_front();
                    checkOutput("dut3_event_vec", int'(vec3), int'(e.vec));
                    checkOutput("dut3_event_cycle", cyc, e.cyc);
                end
                prev3 = vec3;
            end
        end
    end

    initial begin
        num_checks = 0;
        num_fails  = 0;
        mon_en     = 1'b0;
        prev1      = 7'b0001000;
        prev3      = 7'b0001000;
        req_a = 1'b0; req_b = 1'b0; req3_a = 1'b0; req3_b = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset_dut1", int'(vec1), int'(7'b0001000));
        checkOutput("reset_dut3", int'(vec3), int'(7'b0001000));
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        $display("[TB] single request from A");
        expect1(1, 7'b0001100);
        expect1(2, 7'b1000100);
        applyStimulus(1, 0, 0, 0, 4);
        expect1(1, 7'b0001000);
        applyStimulus(0, 0, 0, 0, 3);

        $display("[TB] simultaneous requests, round robin");
        expect1(1, 7'b0011100);
        expect1(2, 7'b0110100);
        applyStimulus(1, 1, 0, 0, 4);
        expect1(1, 7'b0011010);
        expect1(2, 7'b0001110);
        expect1(3, 7'b1000110);
        applyStimulus(1, 0, 0, 0, 5);
        expect1(1, 7'b0001000);
        applyStimulus(0, 0, 0, 0, 3);

        $display("[TB] settle abort with SETTLE_CYCLES=3");
        expect3(1, 7'b0011100);
        expect3(3, 7'b0011000);
        applyStimulus(0, 0, 0, 1, 2);
        applyStimulus(0, 0, 0, 0, 4);
        expect3(1, 7'b0001100);
        expect3(4, 7'b1000100);
        applyStimulus(0, 0, 1, 0, 6);
        expect3(1, 7'b0001000);
        applyStimulus(0, 0, 0, 0, 3);

        $display("[TB] async reset mid-grant");
        expect1(1, 7'b0001100);
        expect1(2, 7'b1000100);
        applyStimulus(1, 0, 0, 0, 3);
        expect1(1, 7'b0001000);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_immediate", int'(vec1), int'(7'b0001000));
        @(negedge clk);
        expect1(1, 7'b0001100);
        expect1(2, 7'b1000100);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 3);
        expect1(1, 7'b0001000);
        applyStimulus(0, 0, 0, 0, 3);

`ifdef MUX157_ARB_TIMEOUT_EN
        $display("[TB] forced release after MAX_HOLD");
        expect1(1, 7'b0001100);
        expect1(2, 7'b1000100);
        applyStimulus(1, 0, 0, 0, 3);
        expect1(3, 7'b0001001);
        expect1(4, 7'b0011100);
        expect1(5, 7'b0110100);
        applyStimulus(1, 1, 0, 0, 7);
        expect1(1, 7'b0011010);
        applyStimulus(1, 0, 0, 0, 4);
        checkOutput("lockout_holds_a", int'(vec1), int'(7'b0011010));
        applyStimulus(0, 0, 0, 0, 1);
        expect1(1, 7'b0001110);
        expect1(2, 7'b1000110);
        applyStimulus(1, 0, 0, 0, 4);
        expect1(1, 7'b0001000);
        applyStimulus(0, 0, 0, 0, 3);
`else
        $display("[TB] unbounded grant");
        expect1(1, 7'b0001100);
        expect1(2, 7'b1000100);
        applyStimulus(1, 0, 0, 0, 300);
        checkOutput("long_hold_gnt", int'(vec1), int'(7'b1000100));
        expect1(1, 7'b0001000);
        applyStimulus(0, 0, 0, 0, 3);
`endif

        repeat (3) @(negedge clk);
        checkOutput("dut1_missing_events", q1.size(), 0);
        checkOutput("dut3_missing_events", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
        $finish;
    end

endmodule
